dmem_ctrl: RTL and testbench

//   Request-queue controller directly upstream of the data memory (sync-read, 1-cycle latency,
//   ce/we strobes, dataOut cleared when ce=0). Accepts load/store requests from the core via

---
 rtl/dmem_ctrl_if.sv | 35 +++
 rtl/dmem_ctrl.sv | 157 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// Core-side request/response and memory-side strobe bundle for dmem_ctrl.
// slave = controller view; master = core plus memory view.
interface dmem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    logic              mem_ce;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_dout,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output mem_ce, mem_we, mem_addr, mem_din
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_dout,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  mem_ce, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Generic show-ahead FIFO: head visible combinationally, push/pop same cycle legal.
// Latency: written entry visible at head the cycle after push.
// Backpressure: caller must not push when count == DEPTH.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic [CW-1:0] count_o
);
    logic [W-1:0]  store_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) store_q[wr_ptr_q] <= din_i;
    end

    assign head_o  = store_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// In-order load/store queue in front of a sync-read data memory, with address range check.
// Latency: load accepted at E0 issues E0..E1, response valid from E2; store written at E1.
// Backpressure: req_ready drops at DEPTH queued; queue stalls while a response is unaccepted.
module dmem_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 6,
    parameter int DEPTH     = 4,
    parameter int MEM_WORDS = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_ctrl_if.slave bus,
    output logic       wr_drop,
    output logic       idle
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W+1)'(MEM_WORDS);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              wr_drop_q, wr_drop_d;

    req_t              push_dat, head;
    logic              push, pop, in_range;
    logic [CW-1:0]     count, count_nxt;

    assign push_dat  = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
    assign push      = bus.req_valid & bus.req_ready;
    assign pop       = (state_q == ISSUE);
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign in_range  = ({1'b0, head.addr} < ADDR_LIM);

    sync_fifo #(.W($bits(req_t)), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (push_dat),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            wr_drop_q  <= wr_drop_d;
        end
    end

    // Transitions look at the post-edge occupancy so a push in the same cycle is not missed.
    always_comb begin
        state_d      = state_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        wr_drop_d    = 1'b0;
        bus.mem_ce   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        case (state_q)
            IDLE: begin
                if (count_nxt != '0) state_d = ISSUE;
            end
            ISSUE: begin
                if (in_range) begin
                    bus.mem_ce   = 1'b1;
                    bus.mem_we   = head.we;
                    bus.mem_addr = head.addr;
                    bus.mem_din  = head.wdata;
                end
                if (head.we) begin
                    wr_drop_d = ~in_range;
                    state_d   = (count_nxt != '0) ? ISSUE : IDLE;
                end else if (in_range) begin
                    state_d = WAIT;
                end else begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end
            end
            WAIT: begin
                rsp_data_d = bus.mem_dout;
                rsp_err_d  = 1'b0;
                state_d    = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = (count_nxt != '0) ? ISSUE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = (count < CW'(DEPTH));
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign wr_drop       = wr_drop_q;
    assign idle          = (count == '0) && (state_q == IDLE);
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a sync-read memory model (dout cleared when ce=0).
module tb_dmem_ctrl;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 6;
    localparam int DEPTH     = 4;
    localparam int MEM_WORDS = 48;

    logic clk = 1'b0;
    logic rst_n;
    logic wr_drop, idle;

    int errors = 0;
    int checks = 0;
    int ce_cnt = 0;
    int drop_cnt = 0;

    logic [DATA_W-1:0] mem [64];
    logic [DATA_W-1:0] dout_q = '0;

    dmem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dmem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MEM_WORDS(MEM_WORDS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .wr_drop (wr_drop),
        .idle    (idle)
    );

    always #5 clk = ~clk;

    assign bus.mem_dout = dout_q;

    always @(posedge clk) begin
        if (bus.mem_ce) begin
            ce_cnt <= ce_cnt + 1;
            if (bus.mem_we) begin
                mem[bus.mem_addr] <= bus.mem_din;
                dout_q <= '0;
            end else begin
                dout_q <= mem[bus.mem_addr];
            end
        end else begin
            dout_q <= '0;
        end
        if (wr_drop) drop_cnt <= drop_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_timeout addr=%0d: req_ready=%b required 1", a, bus.req_ready);
        end
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic get_rsp(input string name, input logic [DATA_W-1:0] exp_d, input logic exp_e);
        int n = 0;
        bus.rsp_ready = 1'b1;
        while (!bus.rsp_valid && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: rsp_valid=%b required 1", name, bus.rsp_valid);
        end else begin
            checks++;
            if (bus.rsp_data !== exp_d) begin
                errors++;
                $display("FAIL %s_data: got %h required %h", name, bus.rsp_data, exp_d);
            end
            checks++;
            if (bus.rsp_err !== exp_e) begin
                errors++;
                $display("FAIL %s_err: got %b required %b", name, bus.rsp_err, exp_e);
            end
        end
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!idle && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL %s_idle_timeout: idle=%b required 1", name, idle);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, wr_drop, bus.mem_ce, bus.mem_we, idle}
            !== 7'b1000001) begin
            errors++;
            $display("FAIL %s_flags: rdy,vld,err,drop,ce,we,idle=%b required 1000001", name,
                     {bus.req_ready, bus.rsp_valid, bus.rsp_err, wr_drop, bus.mem_ce, bus.mem_we, idle});
        end
        checks++;
        if (bus.rsp_data !== '0 || bus.mem_addr !== '0 || bus.mem_din !== '0) begin
            errors++;
            $display("FAIL %s_buses: rsp_data=%h mem_addr=%h mem_din=%h required all 0", name,
                     bus.rsp_data, bus.mem_addr, bus.mem_din);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_order();
        push_req(1'b0, 6'd0, '0);
        push_req(1'b0, 6'd3, '0);
        get_rsp("order_ld0", 32'd1000, 1'b0);
        get_rsp("order_ld3", 32'd3000, 1'b0);
        wait_idle("order");
    endtask

    task automatic test_store_load();
        push_req(1'b1, 6'd5, 32'h0000_1234);
        push_req(1'b0, 6'd5, '0);
        get_rsp("st_ld5", 32'h0000_1234, 1'b0);
        wait_idle("st_ld");
    endtask

    task automatic test_latency();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 6'd2;
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if ({bus.mem_ce, bus.mem_we, bus.rsp_valid} !== 3'b100 || bus.mem_addr !== 6'd2) begin
            errors++;
            $display("FAIL lat_e0: ce,we,vld=%b addr=%0d required 100 addr=2",
                     {bus.mem_ce, bus.mem_we, bus.rsp_valid}, bus.mem_addr);
        end
        tick();
        checks++;
        if ({bus.mem_ce, bus.rsp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL lat_e1: ce,vld=%b required 00", {bus.mem_ce, bus.rsp_valid});
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL lat_e2: rsp_valid=%b required 1", bus.rsp_valid);
        end
        get_rsp("lat_ld2", 32'd2000, 1'b0);
        wait_idle("lat");
    endtask

    task automatic test_hold();
        push_req(1'b0, 6'd1, '0);
        for (int i = 0; i < 4 && !bus.rsp_valid; i++) tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'd5000 || bus.mem_ce !== 1'b0) begin
                errors++;
                $display("FAIL hold_cyc%0d: vld=%b data=%0d ce=%b required 1 5000 0",
                         i, bus.rsp_valid, bus.rsp_data, bus.mem_ce);
            end
            tick();
        end
        get_rsp("hold_ld1", 32'd5000, 1'b0);
        wait_idle("hold");
    endtask

    task automatic test_back_to_back();
        push_req(1'b0, 6'd0, '0);
        for (int i = 0; i < 4 && !bus.rsp_valid; i++) tick();
        for (int i = 0; i < 4; i++)
            push_req(1'b1, 6'(10 + i), 32'h11 * (i + 1));
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full: req_ready=%b required 0", bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 6'd14;
        bus.req_wdata = 32'h55;
        tick();
        tick();
        checks++;
        if (bus.req_ready !== 1'b0 || bus.mem_ce !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall: req_ready=%b mem_ce=%b required 0 0", bus.req_ready, bus.mem_ce);
        end
        bus.rsp_ready = 1'b1;
        checks++;
        if (bus.rsp_data !== 32'd1000) begin
            errors++;
            $display("FAIL b2b_ld0: got %0d required 1000", bus.rsp_data);
        end
        tick();
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.mem_ce !== 1'b1 ||
            bus.mem_we !== 1'b1 || bus.mem_addr !== 6'd10 || bus.mem_din !== 32'h11) begin
            errors++;
            $display("FAIL b2b_issue: rdy=%b vld=%b ce=%b we=%b addr=%0d din=%h required 0 0 1 1 10 11",
                     bus.req_ready, bus.rsp_valid, bus.mem_ce, bus.mem_we, bus.mem_addr, bus.mem_din);
        end
        tick();
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_pop: req_ready=%b required 1", bus.req_ready);
        end
        tick();
        bus.req_valid = 1'b0;
        wait_idle("b2b");
        push_req(1'b0, 6'd14, '0);
        get_rsp("b2b_ld14", 32'h55, 1'b0);
        push_req(1'b0, 6'd10, '0);
        get_rsp("b2b_ld10", 32'h11, 1'b0);
        wait_idle("b2b_rb");
    endtask

    task automatic test_range();
        int ce0, d0;
        push_req(1'b0, 6'd47, '0);
        get_rsp("rng_ld47", 32'd47000, 1'b0);
        wait_idle("rng_edge");
        tick();
        ce0 = ce_cnt;
        push_req(1'b0, 6'd50, '0);
        get_rsp("rng_ld50", 32'd0, 1'b1);
        checks++;
        if (ce_cnt !== ce0) begin
            errors++;
            $display("FAIL rng_ld_ce: ce cycles=%0d required %0d", ce_cnt, ce0);
        end
        d0 = drop_cnt;
        push_req(1'b1, 6'd60, 32'hdead_beef);
        wait_idle("rng_st");
        tick();
        tick();
        checks++;
        if (drop_cnt !== d0 + 1 || ce_cnt !== ce0) begin
            errors++;
            $display("FAIL rng_st_drop: drops=%0d ce=%0d required %0d %0d", drop_cnt, ce_cnt, d0 + 1, ce0);
        end
    endtask

    task automatic test_reset_wait();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 6'd3;
        tick();
        bus.req_addr  = 6'd0;
        tick();
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_wait");
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (idle !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_flush: idle=%b rsp_valid=%b required 1 0", idle, bus.rsp_valid);
        end
        push_req(1'b0, 6'd2, '0);
        get_rsp("rst_ld2", 32'd2000, 1'b0);
        wait_idle("rst_wait");
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'(i * 1000);
        mem[0] = 32'd1000;
        mem[1] = 32'd5000;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_order();
        test_store_load();
        test_latency();
        test_hold();
        test_back_to_back();
        test_range();
        test_reset_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
